// File: rtl/alarm_clock_core_if.sv
// Control and display bundle for alarm_clock_core: board-side controls in, time/alarm/tone out.
// master = board/debouncer side, slave = the clock core.
interface alarm_clock_core_if;
  logic       speed_sel;
  logic [1:0] mode;
  logic       inc_hour;
  logic       inc_min;
  logic       alarm_en;
  logic       stop;
  logic       snooze;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_mins;
  logic       ringing;
  logic       buzzer;
  logic       blink;

  modport master (
    output speed_sel, mode, inc_hour, inc_min, alarm_en, stop, snooze,
    input  hours, minutes, seconds, alarm_hours, alarm_mins, ringing, buzzer, blink
  );

  modport slave (
    input  speed_sel, mode, inc_hour, inc_min, alarm_en, stop, snooze,
    output hours, minutes, seconds, alarm_hours, alarm_mins, ringing, buzzer, blink
  );
endinterface

// File: rtl/alarm_clock_core.sv
// 24 h alarm-clock engine: tick divider, HH:MM:SS counter, alarm register, alarm FSM, buzzer tone.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and honour the snooze input.
module alarm_clock_core #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FAST_DIV   = 1000,
  parameter int unsigned TONE_DIV   = 113636,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic                clock,
  input  logic                reset,
  alarm_clock_core_if.slave   ctl
);

  localparam int unsigned LIM_S = CLK_HZ;
  localparam int unsigned LIM_F = CLK_HZ / FAST_DIV;
  localparam int unsigned CW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TW    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int unsigned RW    = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

  localparam logic [CW-1:0] TOP_S  = CW'(LIM_S - 1);
  localparam logic [CW-1:0] TOP_F  = CW'(LIM_F - 1);
  localparam logic [CW-1:0] HALF_S = CW'(LIM_S / 2);
  localparam logic [CW-1:0] HALF_F = CW'(LIM_F / 2);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
`else
  typedef enum logic {IDLE, RING} state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] div_cnt, div_nxt, top, half;
  logic          spd_q, tick, run, set_time, set_alarm, match, abort;
  logic [4:0]    hr, hr_n, ahr, ahr_n;
  logic [5:0]    mn, mn_n, sc, sc_n, amn, amn_n;
  logic [RW-1:0] ring_cnt;
  logic [TW-1:0] tone_cnt;
  logic          buz_q, ring_q, blink_q;

  assign set_time  = (ctl.mode == 2'b01);
  assign set_alarm = (ctl.mode == 2'b10);
  assign run       = !set_time && !set_alarm;

  // A speed change restarts the divider so the new period starts cleanly from 0.
  always_comb begin
    top     = ctl.speed_sel ? TOP_F : TOP_S;
    half    = ctl.speed_sel ? HALF_F : HALF_S;
    tick    = 1'b0;
    div_nxt = div_cnt + 1'b1;
    if (set_time || (ctl.speed_sel != spd_q)) begin
      div_nxt = '0;
    end else if (div_cnt == top) begin
      div_nxt = '0;
      tick    = 1'b1;
    end
  end

  always_comb begin
    hr_n  = hr;
    mn_n  = mn;
    sc_n  = sc;
    ahr_n = ahr;
    amn_n = amn;
    if (set_time) begin
      sc_n = '0;
      if (ctl.inc_min)  mn_n = (mn == 6'd59) ? '0 : mn + 6'd1;
      if (ctl.inc_hour) hr_n = (hr == 5'd23) ? '0 : hr + 5'd1;
    end else if (tick) begin
      if (sc != 6'd59) begin
        sc_n = sc + 6'd1;
      end else begin
        sc_n = '0;
        if (mn != 6'd59) begin
          mn_n = mn + 6'd1;
        end else begin
          mn_n = '0;
          hr_n = (hr == 5'd23) ? '0 : hr + 5'd1;
        end
      end
    end
    if (set_alarm) begin
      if (ctl.inc_min)  amn_n = (amn == 6'd59) ? '0 : amn + 6'd1;
      if (ctl.inc_hour) ahr_n = (ahr == 5'd23) ? '0 : ahr + 5'd1;
    end
  end

  assign match = tick && run && ctl.alarm_en && (sc_n == '0) && (hr_n == ahr) && (mn_n == amn);
  assign abort = ctl.stop || !ctl.alarm_en || !run;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int unsigned SW        = (SNZ_TICKS > 1) ? $clog2(SNZ_TICKS) : 1;
  localparam logic [SW-1:0] SNZ_LAST = SW'(SNZ_TICKS - 1);
  logic [SW-1:0] snz_cnt;
  logic          snz_done;

  always_ff @(posedge clock) begin
    if (!reset)                               snz_cnt <= '0;
    else if (state != SNOOZE)                 snz_cnt <= '0;
    else if (tick && (state_n == SNOOZE))     snz_cnt <= snz_cnt + 1'b1;
  end

  assign snz_done = tick && (snz_cnt == SNZ_LAST);
`else
  logic unused_snooze;
  assign unused_snooze = ctl.snooze;
`endif

  // Stop outranks snooze, snooze outranks the ring timeout.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (match) state_n = RING;
      RING: begin
        if (abort) state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (ctl.snooze) state_n = SNOOZE;
`endif
        else if (tick && (ring_cnt == RING_LAST)) state_n = IDLE;
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (abort)         state_n = IDLE;
        else if (snz_done) state_n = RING;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt  <= '0;
      spd_q    <= ctl.speed_sel;
      hr       <= '0;
      mn       <= '0;
      sc       <= '0;
      ahr      <= '0;
      amn      <= '0;
      state    <= IDLE;
      ring_cnt <= '0;
      tone_cnt <= '0;
      buz_q    <= 1'b0;
      ring_q   <= 1'b0;
      blink_q  <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      spd_q   <= ctl.speed_sel;
      hr      <= hr_n;
      mn      <= mn_n;
      sc      <= sc_n;
      ahr     <= ahr_n;
      amn     <= amn_n;
      state   <= state_n;
      ring_q  <= (state_n == RING);
      blink_q <= run || (div_nxt < half);
      if ((state_n == RING) && (state != RING))      ring_cnt <= '0;
      else if ((state_n == RING) && tick)            ring_cnt <= ring_cnt + 1'b1;
      if ((state_n == RING) && (state == RING)) begin
        if (tone_cnt == TONE_LAST) begin
          tone_cnt <= '0;
          buz_q    <= ~buz_q;
        end else begin
          tone_cnt <= tone_cnt + 1'b1;
        end
      end else begin
        tone_cnt <= '0;
        buz_q    <= 1'b0;
      end
    end
  end

  assign ctl.hours       = hr;
  assign ctl.minutes     = mn;
  assign ctl.seconds     = sc;
  assign ctl.alarm_hours = ahr;
  assign ctl.alarm_mins  = amn;
  assign ctl.ringing     = ring_q;
  assign ctl.buzzer      = buz_q;
  assign ctl.blink       = blink_q;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core: directed scenarios plus randomized traffic against a
// seconds-of-day behavioural model compared on every falling clock edge.
`timescale 1ns/1ps
module tb_alarm_clock_core;
  localparam int unsigned CLK_HZ = 100, FAST_DIV = 10, TONE_DIV = 4, RING_SEC = 3, SNOOZE_MIN = 1;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  alarm_clock_core_if ctl();

  alarm_clock_core #(
    .CLK_HZ(CLK_HZ), .FAST_DIV(FAST_DIV), .TONE_DIV(TONE_DIV),
    .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ctl(ctl)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time as seconds-of-day, alarm as minute-of-day, alarm life as flags and tick counts.
  int m_tod, m_alm, m_phase, m_rticks, m_sticks, m_age;
  bit m_spd, m_ring, m_snz, m_buz, m_blink;

  always @(posedge clock) begin
    int lim, h, m;
    bit run, tick, match;
    if (!reset) begin
      m_tod = 0; m_alm = 0; m_phase = 0; m_spd = ctl.speed_sel;
      m_ring = 0; m_snz = 0; m_rticks = 0; m_sticks = 0; m_age = 0;
      m_buz = 0; m_blink = 1;
    end else begin
      lim  = ctl.speed_sel ? CLK_HZ / FAST_DIV : CLK_HZ;
      run  = (ctl.mode == 2'b00) || (ctl.mode == 2'b11);
      tick = 0;
      if (ctl.mode == 2'b01 || ctl.speed_sel != m_spd) m_phase = 0;
      else if (m_phase == lim - 1) begin m_phase = 0; tick = 1; end
      else m_phase++;
      m_spd = ctl.speed_sel;
      if (ctl.mode == 2'b01) begin
        h = m_tod / 3600; m = (m_tod / 60) % 60;
        if (ctl.inc_hour) h = (h + 1) % 24;
        if (ctl.inc_min)  m = (m + 1) % 60;
        m_tod = h * 3600 + m * 60;
      end else if (tick) begin
        m_tod = (m_tod + 1) % 86400;
      end
      if (ctl.mode == 2'b10) begin
        h = m_alm / 60; m = m_alm % 60;
        if (ctl.inc_hour) h = (h + 1) % 24;
        if (ctl.inc_min)  m = (m + 1) % 60;
        m_alm = h * 60 + m;
      end
      match = tick && run && ctl.alarm_en && (m_tod % 60 == 0) && (m_tod / 60 == m_alm);
      if (m_ring) begin
        if (ctl.stop || !ctl.alarm_en || !run) m_ring = 0;
        else if (SNZ && ctl.snooze) begin m_ring = 0; m_snz = 1; m_sticks = 0; end
        else if (tick) begin
          m_rticks++;
          if (m_rticks == RING_SEC) m_ring = 0;
        end
        if (m_ring) m_age++;
      end else if (m_snz) begin
        if (ctl.stop || !ctl.alarm_en || !run) m_snz = 0;
        else if (tick) begin
          m_sticks++;
          if (m_sticks == SNOOZE_MIN * 60) begin m_snz = 0; m_ring = 1; m_rticks = 0; m_age = 0; end
        end
      end else if (match) begin
        m_ring = 1; m_rticks = 0; m_age = 0;
      end
      m_buz   = m_ring && ((m_age / TONE_DIV) % 2 == 1);
      m_blink = run || (m_phase < lim / 2);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("hours",       ctl.hours,       m_tod / 3600);
      check("minutes",     ctl.minutes,     (m_tod / 60) % 60);
      check("seconds",     ctl.seconds,     m_tod % 60);
      check("alarm_hours", ctl.alarm_hours, m_alm / 60);
      check("alarm_mins",  ctl.alarm_mins,  m_alm % 60);
      check("ringing",     ctl.ringing,     m_ring);
      check("buzzer",      ctl.buzzer,      m_buz);
      check("blink",       ctl.blink,       m_blink);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_hour(input int n);
    repeat (n) begin ctl.inc_hour = 1'b1; step(); ctl.inc_hour = 1'b0; step(); end
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin ctl.inc_min = 1'b1; step(); ctl.inc_min = 1'b0; step(); end
  endtask

  task automatic wait_ring(input bit lvl, input int budget, input string name);
    int n = 0;
    while (ctl.ringing !== lvl && n < budget) begin step(); n++; end
    check(name, ctl.ringing, lvl);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hours"},   ctl.hours, 0);
    check({tag, "_minutes"}, ctl.minutes, 0);
    check({tag, "_seconds"}, ctl.seconds, 0);
    check({tag, "_alarm"},   {ctl.alarm_hours, ctl.alarm_mins}, 0);
    check({tag, "_ringing"}, ctl.ringing, 0);
    check({tag, "_buzzer"},  ctl.buzzer, 0);
    check({tag, "_blink"},   ctl.blink, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int target, seg_len, n;
    ctl.speed_sel = 0; ctl.mode = 2'b00; ctl.inc_hour = 0; ctl.inc_min = 0;
    ctl.alarm_en = 0; ctl.stop = 0; ctl.snooze = 0;

    // Reset and slow tick period
    step(); chk_en = 1'b1;
    step(2);
    check_reset_vals("reset");
    reset = 1'b1;
    step(99);  check("slow_tick_early", ctl.seconds, 0);
    step(1);   check("slow_tick_at_100", ctl.seconds, 1);

    // Set time: wrap rules, frozen seconds
    ctl.mode = 2'b01;
    pulse_hour(25); pulse_min(61);
    check("set_hours_wrap", ctl.hours, 1);
    check("set_mins_wrap", ctl.minutes, 1);
    check("set_secs_frozen", ctl.seconds, 0);
    pulse_hour(22); pulse_min(58);
    ctl.speed_sel = 1'b1; step(2);
    ctl.mode = 2'b00;
    step(9);   check("fast_tick_early", ctl.seconds, 0);
    step(1);   check("fast_tick_at_10", ctl.seconds, 1);
    step(590);
    check("midnight_wrap", {ctl.hours, ctl.minutes, ctl.seconds}, 0);

    // Alarm at 00:01, tone and auto-stop
    ctl.mode = 2'b10; pulse_min(1); ctl.mode = 2'b00; ctl.alarm_en = 1'b1;
    wait_ring(1, 700, "ring_0001");
    check("ring_time", ctl.minutes * 60 + ctl.seconds, 60);
    check("buzzer_entry", ctl.buzzer, 0);
    step(3); check("buzzer_before_toggle", ctl.buzzer, 0);
    step(1); check("buzzer_first_toggle", ctl.buzzer, 1);
    step(4); check("buzzer_second_toggle", ctl.buzzer, 0);
    wait_ring(0, 100, "auto_stop");
    check("auto_stop_second", ctl.seconds, 3);

    // Stop and snooze together: stop wins
    ctl.mode = 2'b10; pulse_min(1); ctl.mode = 2'b00;
    wait_ring(1, 700, "ring_0002");
    ctl.stop = 1'b1; ctl.snooze = 1'b1; step();
    ctl.stop = 1'b0; ctl.snooze = 1'b0;
    check("stop_wins_ringing", ctl.ringing, 0);
    check("stop_buzzer", ctl.buzzer, 0);
    n = 0;
    while (ctl.seconds != 1 && n < 50) begin step(); n++; end
    check("no_retrigger_sec", ctl.seconds, 1);
    check("no_retrigger", ctl.ringing, 0);

    // Snooze
    ctl.mode = 2'b10; pulse_min(1); ctl.mode = 2'b00;
    wait_ring(1, 700, "ring_0003");
    ctl.snooze = 1'b1; step(); ctl.snooze = 1'b0;
    check("snooze_effect", ctl.ringing, SNZ ? 0 : 1);
    if (SNZ) begin
      wait_ring(1, 700, "snooze_rering");
      check("snooze_rering_time", ctl.minutes * 60 + ctl.seconds, 240);
    end else begin
      step(5); check("snooze_ignored", ctl.ringing, 1);
    end

    // Reset mid-ring, then mid-set
    reset = 1'b0; step();
    check_reset_vals("ring_reset");
    reset = 1'b1; ctl.mode = 2'b01;
    pulse_hour(3);
    check("set_before_reset", ctl.hours, 3);
    reset = 1'b0; step();
    check_reset_vals("set_reset");
    reset = 1'b1; ctl.mode = 2'b00;

    // Randomized traffic: aim the alarm two minutes ahead, then disturb the clock
    for (int seg = 0; seg < 25; seg++) begin
      ctl.mode = 2'b10; ctl.alarm_en = 1'b1; step();
      target = (m_tod / 60 + 2) % 1440;
      for (int g = 0; g < 30 && m_alm / 60 != target / 60; g++) pulse_hour(1);
      for (int g = 0; g < 70 && m_alm % 60 != target % 60; g++) pulse_min(1);
      ctl.mode = 2'b00;
      seg_len = $urandom_range(1500, 900);
      for (int c = 0; c < seg_len; c++) begin
        int r;
        r = $urandom_range(999);
        if (r < 2) ctl.mode = 2'($urandom_range(3));
        else if (r < 20) ctl.mode = 2'b00;
        if ($urandom_range(1499) == 0) ctl.speed_sel = ~ctl.speed_sel;
        if ($urandom_range(799) == 0) ctl.alarm_en = ~ctl.alarm_en;
        ctl.stop     = ($urandom_range(399) == 0);
        ctl.snooze   = ($urandom_range(199) == 0);
        ctl.inc_hour = ($urandom_range(39) == 0);
        ctl.inc_min  = ($urandom_range(39) == 0);
        reset        = ($urandom_range(7999) != 0);
        step();
      end
      reset = 1'b1; ctl.stop = 0; ctl.snooze = 0; ctl.inc_hour = 0; ctl.inc_min = 0;
      ctl.speed_sel = 1'b1;
    end

    ctl.mode = 2'b00;
    step(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
